// File: rtl/m_phy_pkg.sv
// Shared M-PHY TX definitions: line states, TX state machine codes and the
// PWM burst encoder state encoding.
package m_phy_pkg;

  localparam logic [1:0] DIF_N = 2'd0;
  localparam logic [1:0] DIF_P = 2'd1;
  localparam logic [1:0] DIF_Q = 2'd2;
  localparam logic [1:0] DIF_Z = 2'd3;

  localparam logic [1:0] PHY_OTHER = 2'b00;
  localparam logic [1:0] PHY_PWM   = 2'b01;
  localparam logic [1:0] PHY_CFG   = 2'b10;
  localparam logic [1:0] PHY_HS    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREPARE,
    ST_LOAD,
    ST_BIT_P,
    ST_BIT_N,
    ST_TAIL
  } enc_state_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/m_phy_pwm_bit_gen.sv
// Times one self-clocked PWM bit: P phase of 2 or 1 thirds, then N phase of
// 1 or 2 thirds, 3*T_THIRD clocks in total.
module m_phy_pwm_bit_gen #(
  parameter int unsigned T_THIRD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic p_end,
  output logic bit_done
);

  localparam int unsigned BIT_LEN = 3 * T_THIRD;
  localparam int unsigned BW      = $clog2(BIT_LEN);

  logic [BW-1:0] cnt;
  logic [BW-1:0] p_len;

  assign p_len    = bit_val ? BW'(2 * T_THIRD) : BW'(T_THIRD);
  assign p_end    = (cnt == p_len - 1'b1);
  assign bit_done = (cnt == BW'(BIT_LEN - 1));

  // start holds the counter at zero while the encoder is outside a bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/m_phy_tx_pwm_enc.sv
// PWM burst encoder: PREPARE (DIF-P), PWM bit stream, tail-of-burst (DIF-N).
//
// state   | meaning
// IDLE    | line DIF-N, waiting for burst_req with phy_state OTHER
// PREPARE | line DIF-P, waiting for phy_state PWM_BURST or timeout
// LOAD    | line DIF-N, tx_ready high, take a symbol or finish on tx_end
// BIT_P   | P phase of the current bit
// BIT_N   | N phase of the current bit, then next bit or LOAD
// TAIL    | line DIF-N for T_TAIL clocks, then pwm_done
module m_phy_tx_pwm_enc
  import m_phy_pkg::*;
#(
  parameter int unsigned T_THIRD      = 4,
  parameter int unsigned T_TAIL       = 8,
  parameter int unsigned PREP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] phy_state,
  input  logic       burst_req,
  input  logic [9:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_end,
  output logic [1:0] line_state,
  output logic       busy,
  output logic       pwm_done,
  output logic       prep_err
);

  localparam int unsigned CNT_W = $clog2(max3(2 * T_THIRD, T_TAIL, PREP_TIMEOUT));

  enc_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [9:0]       shreg, shreg_nx;
  logic [3:0]       bit_idx, bit_idx_nx;
  logic [1:0]       line_nx;
  logic             pwm_done_nx, prep_err_nx;
  logic             gen_start, gen_p_end, gen_bit_done;

  assign tx_ready  = (state == ST_LOAD);
  assign gen_start = (state != ST_BIT_P) && (state != ST_BIT_N);

  m_phy_pwm_bit_gen #(
    .T_THIRD (T_THIRD)
  ) u_bit_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (gen_start),
    .bit_val  (shreg[0]),
    .p_end    (gen_p_end),
    .bit_done (gen_bit_done)
  );

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_idx_nx  = bit_idx;
    pwm_done_nx = 1'b0;
    prep_err_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (burst_req && phy_state == PHY_OTHER) state_nx = ST_PREPARE;
      end
      ST_PREPARE: begin
        if (phy_state == PHY_PWM) begin
          state_nx = ST_LOAD;
        end else if (cnt == CNT_W'(PREP_TIMEOUT - 1)) begin
          state_nx    = ST_IDLE;
          prep_err_nx = 1'b1;
        end
      end
      ST_LOAD: begin
        if (tx_valid) begin
          shreg_nx   = tx_data;
          bit_idx_nx = 4'd0;
          state_nx   = ST_BIT_P;
        end else if (tx_end) begin
          state_nx = ST_TAIL;
        end
      end
      ST_BIT_P: begin
        if (gen_p_end) state_nx = ST_BIT_N;
      end
      ST_BIT_N: begin
        if (gen_bit_done) begin
          if (bit_idx == 4'd9) begin
            state_nx = ST_LOAD;
          end else begin
            shreg_nx   = shreg >> 1;
            bit_idx_nx = bit_idx + 4'd1;
            state_nx   = ST_BIT_P;
          end
        end
      end
      ST_TAIL: begin
        if (cnt == CNT_W'(T_TAIL - 1)) begin
          state_nx    = ST_IDLE;
          pwm_done_nx = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // SM left PWM_BURST (rct, sap_reset, phy_reset): drop the burst silently
    if ((state inside {ST_LOAD, ST_BIT_P, ST_BIT_N, ST_TAIL}) && phy_state != PHY_PWM) begin
      state_nx    = ST_IDLE;
      pwm_done_nx = 1'b0;
      shreg_nx    = shreg;
      bit_idx_nx  = bit_idx;
    end

    if (state_nx != state) begin
      cnt_nx = '0;
    end else if (state == ST_PREPARE || state == ST_TAIL) begin
      cnt_nx = cnt + 1'b1;
    end else begin
      cnt_nx = cnt;
    end

    line_nx = (state_nx == ST_PREPARE || state_nx == ST_BIT_P) ? DIF_P : DIF_N;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      line_state <= DIF_N;
      busy       <= 1'b0;
      pwm_done   <= 1'b0;
      prep_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      bit_idx    <= bit_idx_nx;
      line_state <= line_nx;
      busy       <= (state_nx != ST_IDLE);
      pwm_done   <= pwm_done_nx;
      prep_err   <= prep_err_nx;
    end
  end

endmodule

// File: tb/tb_m_phy_tx_pwm_enc.sv
// Scoreboard bench for m_phy_tx_pwm_enc: expected line-state runs and pulses
// are queued by the stimulus and consumed by a negedge monitor.
module tb_m_phy_tx_pwm_enc;

  localparam int EV_RUN  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam logic [1:0] LN = 2'd0;
  localparam logic [1:0] LP = 2'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] phy_state = 2'b00;
  logic       burst_req = 1'b0;
  logic [9:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_end = 1'b0;
  logic [1:0] line_state;
  logic       busy;
  logic       pwm_done;
  logic       prep_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [1:0] ls;
    int         len;
  } ev_t;

  ev_t exp_q[$];

  m_phy_tx_pwm_enc dut (
    .clk        (clk),
    .reset      (reset),
    .phy_state  (phy_state),
    .burst_req  (burst_req),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_end     (tx_end),
    .line_state (line_state),
    .busy       (busy),
    .pwm_done   (pwm_done),
    .prep_err   (prep_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // len 0 means the run length is not checked
  task automatic push(input int kind, input logic [1:0] ls, input int len);
    ev_t e;
    e.kind = kind;
    e.ls   = ls;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [1:0] ls, input int len);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d ls=%0d len=%0d expected none", kind, ls, len);
    end else begin
      e = exp_q.pop_front();
      if (kind != e.kind || ls != e.ls || (e.len != 0 && len != e.len)) begin
        errors++;
        $display("FAIL event_%0d got kind=%0d ls=%0d len=%0d expected kind=%0d ls=%0d len=%0d",
                 checks, kind, ls, len, e.kind, e.ls, e.len);
      end
    end
  endtask

  // Monitor: emits a run event on every line_state change, plus pulse events
  initial begin
    logic [1:0] cur_ls;
    logic [1:0] ls;
    int         run_len;
    cur_ls  = LN;
    run_len = 0;
    forever begin
      @(negedge clk);
      ls = line_state;
      if (ls != cur_ls) begin
        check_ev(EV_RUN, cur_ls, run_len);
        cur_ls  = ls;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (pwm_done) check_ev(EV_DONE, ls, run_len);
      if (prep_err) check_ev(EV_ERR, ls, run_len);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] sym;
    bit         seen;

    // reset values, asserted before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_line_state", line_state, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pwm_done", pwm_done, 0);
    chk("rst_prep_err", prep_err, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // start, symbol 0000000001 with tx_end also high, then end of burst
    push(EV_RUN, LN, 0);
    push(EV_RUN, LP, 17);
    push(EV_RUN, LN, 1);
    push(EV_RUN, LP, 8);
    push(EV_RUN, LN, 4);
    for (int b = 1; b <= 8; b++) begin
      push(EV_RUN, LP, 4);
      push(EV_RUN, LN, 8);
    end
    push(EV_RUN, LP, 4);
    push(EV_DONE, LN, 18);   // bit9 N 8 + LOAD 1 + TAIL 8 + done cycle
    burst_req = 1'b1;
    tick();
    burst_req = 1'b0;
    chk("prep_busy", busy, 1);
    repeat (16) tick();
    phy_state = 2'b01;
    tick();
    chk("load_tx_ready", tx_ready, 1);
    chk("load_busy", busy, 1);
    tx_data  = 10'b0000000001;
    tx_valid = 1'b1;
    tx_end   = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("bitp_tx_ready", tx_ready, 0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (pwm_done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("done_busy", busy, 0);
    chk("done_line", line_state, 0);
    tx_end    = 1'b0;
    phy_state = 2'b00;
    repeat (3) tick();

    // PREPARE timeout
    push(EV_RUN, LN, 0);
    push(EV_RUN, LP, 64);
    push(EV_ERR, LN, 1);
    burst_req = 1'b1;
    tick();
    burst_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (prep_err) seen = 1'b1;
    end
    chk("timeout_seen", seen, 1);
    chk("timeout_busy", busy, 0);
    repeat (3) tick();

    // abort in the middle of bit 5 (P phase of a 1)
    sym = 10'b0110100110;
    push(EV_RUN, LN, 0);
    push(EV_RUN, LP, 1);
    push(EV_RUN, LN, 1);
    for (int b = 0; b < 5; b++) begin
      push(EV_RUN, LP, sym[b] ? 8 : 4);
      push(EV_RUN, LN, sym[b] ? 4 : 8);
    end
    push(EV_RUN, LP, 3);
    burst_req = 1'b1;
    tick();
    burst_req = 1'b0;
    phy_state = 2'b01;
    tick();
    tx_data  = sym;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (62) tick();
    phy_state = 2'b00;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_line", line_state, 0);
    repeat (20) tick();

    // async reset during BIT_P
    push(EV_RUN, LN, 0);
    push(EV_RUN, LP, 1);
    push(EV_RUN, LN, 1);
    push(EV_RUN, LP, 2);
    burst_req = 1'b1;
    tick();
    burst_req = 1'b0;
    phy_state = 2'b01;
    tick();
    tx_data  = 10'h3FF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (2) tick();
    chk("pre_rst_line", line_state, 1);
    reset = 1'b1;
    #1;
    chk("arst_line", line_state, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_ready", tx_ready, 0);
    phy_state = 2'b00;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("after_rst_busy", busy, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
